// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the RV64 data-memory access unit: funct3 width codes,
// FSM state encoding and the default memory size.
package mem_access_unit_pkg;

  localparam int unsigned MEM_BYTES_DEFAULT = 64;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic {
    ST_IDLE,
    ST_RMW_WR
  } state_t;

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational width selection and sign/zero extension of a doubleword read.
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  funct3,
  output logic [63:0] ext
);

  always_comb begin
    ext = rdata;
    case (funct3)
      F3_B:    ext = {{56{rdata[7]}},  rdata[7:0]};
      F3_H:    ext = {{48{rdata[15]}}, rdata[15:0]};
      F3_W:    ext = {{32{rdata[31]}}, rdata[31:0]};
      F3_BU:   ext = {56'd0, rdata[7:0]};
      F3_HU:   ext = {48'd0, rdata[15:0]};
      F3_WU:   ext = {32'd0, rdata[31:0]};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Translates RV64 load/store requests into full-doubleword memory accesses;
// narrow stores become a stalled two-cycle read-modify-write.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int unsigned XLEN      = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            mem_read_in,
  input  logic            mem_write_in,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            stall,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_read,
  output logic            mem_write,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] load_result,
  output logic            result_valid,
  output logic            access_fault
);

  localparam logic [XLEN-1:0] MAX_ADDR = XLEN'(MEM_BYTES - 8);

  state_t          state_q, state_d;
  logic [XLEN-1:0] merge_reg, held_addr;
  logic [XLEN-1:0] load_ext, store_mask, merged;

  logic is_load, is_store, addr_bad, fault;
  logic load_ok, store_d_ok, store_narrow_ok;

  assign is_load  = req_valid & mem_read_in  & ~mem_write_in;
  assign is_store = req_valid & mem_write_in & ~mem_read_in;
  assign addr_bad = addr > MAX_ADDR;

  assign fault = req_valid & ((mem_read_in & mem_write_in)
               | ((mem_read_in | mem_write_in) & addr_bad)
               | (is_load  & (funct3 == 3'b111))
               | (is_store & funct3[2]));

  assign load_ok         = is_load & ~fault;
  assign store_d_ok      = is_store & ~fault & (funct3 == F3_D);
  assign store_narrow_ok = is_store & ~fault & (funct3 != F3_D);

  load_extend u_load_ext (
    .rdata  (mem_rdata),
    .funct3 (funct3),
    .ext    (load_ext)
  );

  // Zero-extending an all-ones word yields the byte mask of the store width.
  load_extend u_mask_gen (
    .rdata  ('1),
    .funct3 ({1'b1, funct3[1:0]}),
    .ext    (store_mask)
  );

  assign merged = (mem_rdata & ~store_mask) | (store_data & store_mask);

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = addr;
    mem_wdata = store_data;
    case (state_q)
      ST_IDLE: begin
        if (load_ok) begin
          mem_read = 1'b1;
        end else if (store_d_ok) begin
          mem_write = ~reset;
        end else if (store_narrow_ok) begin
          mem_read = 1'b1;
          stall    = 1'b1;
          state_d  = ST_RMW_WR;
        end
      end
      ST_RMW_WR: begin
        mem_addr  = held_addr;
        mem_wdata = merge_reg;
        mem_write = ~reset;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      load_result  <= '0;
      result_valid <= 1'b0;
      access_fault <= 1'b0;
      merge_reg    <= '0;
      held_addr    <= '0;
    end else begin
      state_q      <= state_d;
      result_valid <= 1'b0;
      access_fault <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (fault) begin
          access_fault <= 1'b1;
          result_valid <= mem_read_in;
          load_result  <= '0;
        end else if (load_ok) begin
          load_result  <= load_ext;
          result_valid <= 1'b1;
        end else if (store_narrow_ok) begin
          merge_reg <= merged;
          held_addr <= addr;
        end
      end
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the EX/MEM pipeline register and the byte-addressed 64-bit data memory.
- Converts RV64 load/store requests (funct3-encoded width) into the memory's full-doubleword read/write ports.
- Sub-doubleword stores (SB/SH/SW) become a 2-cycle read-modify-write with a pipeline stall, so adjacent bytes are preserved.
- Loads return a registered, sign- or zero-extended result to the MEM/WB stage.

Parameters:
- MEM_BYTES, 64, data memory size in bytes; the highest legal doubleword start address is MEM_BYTES-8.
- XLEN, 64, data and address width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  a memory instruction is present in the MEM stage.
- mem_read_in  input  1  the request is a load.
- mem_write_in  input  1  the request is a store.
- funct3  input  3  access width/sign: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; stores use 000–011.
- addr  input  XLEN  byte address from the ALU.
- store_data  input  XLEN  rs2 value; the low bytes are used for narrow stores.
- stall  output  1  hold the PC, IF/ID, ID/EX and EX/MEM stages this cycle.
- mem_addr  output  XLEN  to data memory Mem_Addr.
- mem_wdata  output  XLEN  to data memory Write_DataMEM.
- mem_read  output  1  to data memory MemRead.
- mem_write  output  1  to data memory MemWrite.
- mem_rdata  input  XLEN  from data memory Read_Data (combinational).
- load_result  output  XLEN  registered, extended load data for MEM/WB.
- result_valid  output  1  load_result is valid this cycle (one-cycle pulse).
- access_fault  output  1  registered one-cycle pulse for an out-of-range address or illegal funct3.

Behaviour:
- Reset values: load_result=0, result_valid=0, access_fault=0, state=IDLE, merge_reg=0, held_addr=0.
- Combinational outputs in IDLE with no request: mem_read=0, mem_write=0, stall=0, mem_addr=addr, mem_wdata=store_data.
- A request is a fault if either holds:
  - addr > MEM_BYTES-8 (unsigned).
  - The funct3 is illegal: 111 on a load, or ≥100 on a store.
  - A faulting request causes no mem_read and no mem_write.
  - Next edge: access_fault=1, result_valid=1 if it was a load, load_result=0.
- mem_read_in and mem_write_in both set: treat as a fault.
- Load (IDLE, req_valid, legal):
  - mem_read=1 combinationally with mem_addr=addr.
  - At the next edge, load_result is taken from mem_rdata: bits [7:0], [15:0], [31:0] or [63:0] per width.
  - Sign-extend for LB/LH/LW; zero-extend for LBU/LHU/LWU.
  - result_valid=1 for one cycle. Latency is 1 cycle and there is no stall.
- SD (IDLE, legal): mem_write=1 and mem_wdata=store_data in the same cycle; no stall; single cycle.
- SB/SH/SW uses an FSM with states IDLE and RMW_WR:
  - IDLE cycle: mem_read=1 at addr and stall=1.
  - At the edge: merge_reg = mem_rdata with its low 1/2/4 bytes replaced by store_data[7:0]/[15:0]/[31:0]; held_addr=addr; go to RMW_WR.
  - RMW_WR cycle: mem_write=1, mem_addr=held_addr, mem_wdata=merge_reg, stall=0, mem_read=0.
  - The write commits at that edge; return to IDLE.
  - Upstream inputs are held stable during the stall. In RMW_WR, req_valid and the other request inputs are ignored (the held instruction completes).
- result_valid and access_fault are 0 in every cycle without a qualifying event.
- Misaligned addresses are legal; the memory is byte-addressed and needs no split.
- Wrap-around: addr+7 arithmetic is never issued out of range because of the fault check.
- Reset asserted in RMW_WR aborts the write: mem_write is forced to 0 while reset=1, and the state returns to IDLE.
- Reset has priority over every event.

Decomposition:
- Shared package, defined there:
  - funct3 width-code constants: F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU.
  - State encoding: ST_IDLE, ST_RMW_WR.
  - MEM_BYTES default.
- One natural sub-module: load_extend. It is combinational: (rdata, funct3) → extended 64-bit value. It is reused by the merge logic's byte-mask generation.

Test Plan:
- Memory byte[0]=0xFF. LB at addr 0 → load_result=0xFFFFFFFFFFFFFFFF, result_valid=1 after 1 cycle, stall=0. LBU at addr 0 → 0x00000000000000FF.
- Memory byte[8]=0xF4, byte[9]=0. LH at addr 8 → 0x00000000000000F4. LD at addr 16 (byte[16]=0x64) → 0x64.
- SB at addr 8 with store_data=0x1122334455667788, memory bytes 8–15 = F4,0,0,0,0,0,0,0:
  - stall=1 for exactly 1 cycle, then mem_write=1 with mem_wdata=0x0000000000000088.
  - A following LD at addr 8 → 0x88. Bytes 9–15 are unchanged.
- SD at addr 24 with 0xDEADBEEFCAFEF00D → mem_write in the same cycle, no stall. LW at addr 24 → 0xFFFFFFFFCAFEF00D; LWU → 0x00000000CAFEF00D.
- LD at addr 57 (MEM_BYTES=64) → no mem_read, access_fault=1 for one cycle, load_result=0. Store with funct3=100 → access_fault=1, no mem_write.
- SW at addr 0 with reset asserted during the RMW_WR cycle → mem_write=0, memory byte[0] still 0xFF, state is IDLE and all outputs are 0 the next cycle.
